// File: rtl/trakball_pkg.sv
// Shared types and constants for the trackball decoder: read-byte layout and default widths.
package trakball_pkg;

    localparam int DOUT_DIR_BIT   = 7;
    localparam int DOUT_MOVED_BIT = 6;
    localparam int PAYLOAD_W      = 6;
    localparam int DEF_CNT_W      = 4;

    typedef struct packed {
        logic                 dir;
        logic                 moved;
        logic [PAYLOAD_W-1:0] payload;
    } trak_byte_t;

    function automatic trak_byte_t pack_byte(input logic dir, input logic moved,
                                             input logic [PAYLOAD_W-1:0] payload);
        trak_byte_t b;
        b.dir     = dir;
        b.moved   = moved;
        b.payload = payload;
        return b;
    endfunction

endpackage

// File: rtl/trakball_decoder_if.sv
// Bus between the trackball emulation / CPU port mux (master) and the decoder (slave).
interface trakball_decoder_if;
    logic       ce;
    logic       flip;
    logic       trak_dir_x;
    logic       trak_clk_x;
    logic       trak_dir_y;
    logic       trak_clk_y;
    logic       rd_x;
    logic       rd_y;
    logic       clr;
    logic [7:0] dout_x;
    logic [7:0] dout_y;

    modport master (
        output ce, flip, trak_dir_x, trak_clk_x, trak_dir_y, trak_clk_y, rd_x, rd_y, clr,
        input  dout_x, dout_y
    );

    modport slave (
        input  ce, flip, trak_dir_x, trak_clk_x, trak_dir_y, trak_clk_y, rd_x, rd_y, clr,
        output dout_x, dout_y
    );
endinterface

// File: rtl/trakball_axis.sv
// One trackball axis: line synchronisers, optional glitch filter (TRAKBALL_DECODER_FILTER_EN),
// rising-edge detect, wrapping up/down counter, direction/moved flags and the read latch.
module trakball_axis
    import trakball_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic       flip,
    input  logic       clr,
    input  logic       rd,
    input  logic       dir_line,
    input  logic       clk_line,
    output trak_byte_t dout
);

    if (SYNC_STAGES < 2) begin : g_sync_err
        $error("trakball_axis: SYNC_STAGES must be >= 2");
    end
    if (FILT_LEN < 1) begin : g_filt_err
        $error("trakball_axis: FILT_LEN must be >= 1");
    end

    // Bit 0 carries the count clock line, bit 1 the direction line.
    logic [1:0] line_in;
    logic [1:0] filt;
    assign line_in = {dir_line, clk_line};

    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [SYNC_STAGES-1:0] sync_q;

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) sync_q <= '0;
            else       sync_q <= {sync_q[SYNC_STAGES-2:0], line_in[i]};
        end

`ifdef TRAKBALL_DECODER_FILTER_EN
        localparam int FW = $clog2(FILT_LEN + 1);
        logic [FW-1:0] stab_q;
        logic          filt_q;

        // Any ce cycle where the synced line agrees with the filtered value restarts the count.
        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                stab_q <= '0;
                filt_q <= 1'b0;
            end else if (ce) begin
                if (sync_q[SYNC_STAGES-1] == filt_q) begin
                    stab_q <= '0;
                end else if (stab_q == FW'(FILT_LEN - 1)) begin
                    filt_q <= sync_q[SYNC_STAGES-1];
                    stab_q <= '0;
                end else begin
                    stab_q <= stab_q + 1'b1;
                end
            end
        end
        assign filt[i] = filt_q;
`else
        assign filt[i] = sync_q[SYNC_STAGES-1];
`endif
    end

    logic             clk_prev_q;
    logic             edge_acc;
    logic             eff_dir;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             moved_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)   clk_prev_q <= 1'b0;
        else if (ce) clk_prev_q <= filt[0];
    end

    assign edge_acc = ce & filt[0] & ~clk_prev_q;
    assign eff_dir  = filt[1] ^ flip;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            moved_q <= 1'b0;
        end else if (clr) begin
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            moved_q <= 1'b0;
        end else if (edge_acc) begin
            cnt_q   <= eff_dir ? cnt_q + 1'b1 : cnt_q - 1'b1;
            dir_q   <= eff_dir;
            moved_q <= 1'b1;
        end else if (rd) begin
            moved_q <= 1'b0;
        end
    end

    // The read latch samples the pre-update state, so a coincident edge or clr is seen next read.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)   dout <= '0;
        else if (rd) dout <= pack_byte(dir_q, moved_q, PAYLOAD_W'(cnt_q));
    end

endmodule

// File: rtl/trakball_decoder.sv
// Two-axis trackball decoder presenting one read byte per axis.
// Optional glitch filter enabled by defining TRAKBALL_DECODER_FILTER_EN.
module trakball_decoder
    import trakball_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input logic               clk_sys,
    input logic               reset,
    trakball_decoder_if.slave bus
);

    if (CNT_W > PAYLOAD_W) begin : g_cnt_w_err
        $error("trakball_decoder: CNT_W must be <= 6");
    end

    // Reset asserts immediately but releases only on a clk_sys edge.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    trak_byte_t dout_x;
    trak_byte_t dout_y;

    trakball_axis #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_axis_x (
        .clk_sys (clk_sys),
        .reset   (rst_int),
        .ce      (bus.ce),
        .flip    (bus.flip),
        .clr     (bus.clr),
        .rd      (bus.rd_x),
        .dir_line(bus.trak_dir_x),
        .clk_line(bus.trak_clk_x),
        .dout    (dout_x)
    );

    trakball_axis #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_axis_y (
        .clk_sys (clk_sys),
        .reset   (rst_int),
        .ce      (bus.ce),
        .flip    (bus.flip),
        .clr     (bus.clr),
        .rd      (bus.rd_y),
        .dir_line(bus.trak_dir_y),
        .clk_line(bus.trak_clk_y),
        .dout    (dout_y)
    );

    assign bus.dout_x = dout_x;
    assign bus.dout_y = dout_y;

endmodule

// File: tb/tb_trakball_decoder.sv
// Testbench for trakball_decoder: vector table plus hand-written corner sequences,
// read results checked through per-axis expected-value queues.
module tb_trakball_decoder;

    // Cycles from driving a count line high to the cycle its edge is accepted.
`ifdef TRAKBALL_DECODER_FILTER_EN
    localparam int EDGE_DLY = 2 + 3;
`else
    localparam int EDGE_DLY = 2;
`endif

    logic clk_sys = 1'b0;
    logic reset;

    always #5 clk_sys = ~clk_sys;

    trakball_decoder_if bus ();

    trakball_decoder dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_x_q[$];
    logic [7:0] exp_y_q[$];
    logic       rd_q_x = 1'b0;
    logic       rd_q_y = 1'b0;

    typedef struct {
        bit         clr_first;
        bit         axis;
        bit         dir;
        bit         flip;
        int         n;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic set_clk(input bit axis, input bit v);
        if (axis) bus.trak_clk_y = v;
        else      bus.trak_clk_x = v;
    endtask

    task automatic set_dir(input bit axis, input bit v);
        if (axis) bus.trak_dir_y = v;
        else      bus.trak_dir_x = v;
    endtask

    task automatic pulse(input bit axis, input int n);
        for (int k = 0; k < n; k++) begin
            set_clk(axis, 1'b1);
            tick(6);
            set_clk(axis, 1'b0);
            tick(6);
        end
    endtask

    task automatic read(input bit axis, input logic [7:0] exp);
        if (axis) begin
            exp_y_q.push_back(exp);
            bus.rd_y = 1'b1;
        end else begin
            exp_x_q.push_back(exp);
            bus.rd_x = 1'b1;
        end
        tick();
        bus.rd_x = 1'b0;
        bus.rd_y = 1'b0;
    endtask

    task automatic clr_pulse();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
    endtask

    // Scoreboard side: a read strobe seen at a clock edge means dout is valid after that edge.
    always @(posedge clk_sys) begin
        rd_q_x <= bus.rd_x;
        rd_q_y <= bus.rd_y;
    end

    always @(negedge clk_sys) begin
        if (rd_q_x) begin
            if (exp_x_q.size() == 0) check("rd_x_unexpected", bus.dout_x, 8'hxx);
            else                     check("rd_x", bus.dout_x, exp_x_q.pop_front());
        end
        if (rd_q_y) begin
            if (exp_y_q.size() == 0) check("rd_y_unexpected", bus.dout_y, 8'hxx);
            else                     check("rd_y", bus.dout_y, exp_y_q.pop_front());
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 0, 1, 0, 3,  8'hC3};
        vecs[1] = '{0, 0, 1, 0, 0,  8'h83};
        vecs[2] = '{1, 0, 1, 0, 0,  8'h00};
        vecs[3] = '{0, 0, 0, 0, 1,  8'h4F};
        vecs[4] = '{0, 0, 1, 0, 16, 8'hCF};
        vecs[5] = '{1, 1, 1, 1, 2,  8'h4E};
        vecs[6] = '{0, 0, 0, 1, 0,  8'h00};
        vecs[7] = '{0, 0, 0, 1, 2,  8'hC2};
        vecs[8] = '{0, 1, 0, 0, 1,  8'h4D};

        reset          = 1'b1;
        bus.ce         = 1'b1;
        bus.flip       = 1'b0;
        bus.trak_dir_x = 1'b0;
        bus.trak_clk_x = 1'b0;
        bus.trak_dir_y = 1'b0;
        bus.trak_clk_y = 1'b0;
        bus.rd_x       = 1'b0;
        bus.rd_y       = 1'b0;
        bus.clr        = 1'b0;
        tick(5);
        check("reset_dout_x", bus.dout_x, 8'h00);
        check("reset_dout_y", bus.dout_y, 8'h00);
        reset = 1'b0;
        tick(6);

        // Reset asserted mid-count.
        bus.trak_dir_x = 1'b1;
        tick(8);
        pulse(0, 5);
        read(0, 8'hC5);
        tick(2);
        #2 reset = 1'b1;
        #1;
        check("async_reset_dout_x", bus.dout_x, 8'h00);
        check("async_reset_cnt_x", 8'(dut.u_axis_x.cnt_q), 8'h00);
        tick(3);
        reset = 1'b0;
        tick(6);
        read(0, 8'h00);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].clr_first) clr_pulse();
            bus.flip = vecs[i].flip;
            set_dir(vecs[i].axis, vecs[i].dir);
            tick(8);
            pulse(vecs[i].axis, vecs[i].n);
            read(vecs[i].axis, vecs[i].exp);
        end

        // clr coincident with an accepted X edge: edge dropped, dout held until next read.
        bus.flip       = 1'b0;
        bus.trak_dir_x = 1'b1;
        tick(8);
        bus.trak_clk_x = 1'b1;
        tick(EDGE_DLY);
        clr_pulse();
        tick(5);
        bus.trak_clk_x = 1'b0;
        tick(6);
        check("clr_holds_dout_x", bus.dout_x, 8'hC2);
        read(0, 8'h00);

        // Read coincident with an accepted edge: pre-update byte, moved survives.
        bus.trak_clk_x = 1'b1;
        tick(EDGE_DLY);
        read(0, 8'h00);
        tick(5);
        bus.trak_clk_x = 1'b0;
        tick(6);
        read(0, 8'hC1);

        // clr and read together: dout gets the pre-clear value.
        exp_x_q.push_back(8'h81);
        bus.rd_x = 1'b1;
        bus.clr  = 1'b1;
        tick();
        bus.rd_x = 1'b0;
        bus.clr  = 1'b0;
        read(0, 8'h00);

        // ce low freezes decoding but reads still work.
        bus.ce = 1'b0;
        pulse(0, 2);
        read(0, 8'h00);
        bus.ce = 1'b1;
        tick(8);
        read(0, 8'h00);

        // Short pulses.
`ifdef TRAKBALL_DECODER_FILTER_EN
        bus.trak_clk_x = 1'b1;
        tick(2);
        bus.trak_clk_x = 1'b0;
        tick(10);
        read(0, 8'h00);
        bus.trak_clk_x = 1'b1;
        tick(4);
        bus.trak_clk_x = 1'b0;
        tick(10);
        read(0, 8'hC1);
`else
        bus.trak_clk_x = 1'b1;
        tick(1);
        bus.trak_clk_x = 1'b0;
        tick(10);
        read(0, 8'hC1);
`endif

        tick(4);
        check("scoreboard_drained", 8'(exp_x_q.size() + exp_y_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
